// File: rtl/pc_state_sequencer.sv
// pc_state_sequencer: six-phase instruction sequencer owning the program counter,
// phase code, branch redirect latch, retire pulse and saturating retire counter.
module pc_state_sequencer #(
   parameter int PC_W   = 8,
   parameter int MAX_PC = 11,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [PC_W-1:0]  br_target,
   output logic [PC_W-1:0]  pc,
   output logic [2:0]       state,
   output logic             retire,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             done
);
   typedef enum logic [2:0] {
      FETCH = 3'd0, DECODE = 3'd1, RF_READ = 3'd2, EXECUTE = 3'd3,
      MEM = 3'd4, WB = 3'd5, BAD = 3'd6, HALT = 3'd7
   } state_t;
   localparam logic [PC_W:0] LAST = (PC_W+1)'(MAX_PC);
   state_t st, st_n;
   logic [PC_W-1:0] pc_n, redir_pc, redir_pc_n;
   logic redir_v, redir_v_n, done_n, stop;
   logic [CNT_W-1:0] cnt_n;
   logic [PC_W:0] nxt;
   assign state = st;
   // nxt carries one extra bit so a wrap past the PC width is detected as a halt
   always_comb begin
      nxt = redir_v ? {1'b0, redir_pc} : {1'b0, pc} + 1'b1;
      stop = {1'b0, pc} == LAST || nxt > LAST || nxt[PC_W];
      retire = st == WB && !stall;
      st_n = st;
      pc_n = pc;
      redir_v_n = redir_v;
      redir_pc_n = redir_pc;
      cnt_n = retired_cnt;
      done_n = done;
      case (st)
         HALT: ;
         BAD: begin
            st_n = HALT;
            done_n = 1'b1;
         end
         default: if (!stall) begin
            st_n = state_t'(st + 3'd1);
            if (st == EXECUTE) begin
               redir_v_n = br_valid;
               redir_pc_n = br_target;
            end
            if (retire) begin
               cnt_n = &retired_cnt ? retired_cnt : retired_cnt + 1'b1;
               redir_v_n = 1'b0;
               st_n = stop ? HALT : FETCH;
               pc_n = stop ? pc : nxt[PC_W-1:0];
               done_n = stop;
            end
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= FETCH;
         pc <= '0;
         redir_v <= 1'b0;
         redir_pc <= '0;
         retired_cnt <= '0;
         done <= 1'b0;
      end else begin
         st <= st_n;
         pc <= pc_n;
         redir_v <= redir_v_n;
         redir_pc <= redir_pc_n;
         retired_cnt <= cnt_n;
         done <= done_n;
      end
   end
endmodule

// File: tb/tb_pc_state_sequencer.sv
// tb_pc_state_sequencer: directed and random stimulus checked against a
// phase/pc reference model; a second CNT_W=3 instance checks counter saturation.
module tb_pc_state_sequencer;
   logic clk = 0;
   logic rst = 1, stall = 0, br_valid = 0;
   logic [7:0] br_target = 0;
   logic [7:0] pc;
   logic [2:0] state;
   logic retire, done;
   logic [15:0] retired_cnt;
   logic rst3 = 1;
   logic [7:0] pc3;
   logic [2:0] state3;
   logic retire3, done3;
   logic [2:0] cnt3;
   int checks = 0, errors = 0;
   int m_ph = 0, m_pc = 0, m_rv = 0, m_rp = 0, m_cnt = 0, m_done = 0;
   int n_ret = 0, stall_left = 0;

   always #5 clk = ~clk;

   pc_state_sequencer dut (
      .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target),
      .pc(pc), .state(state), .retire(retire), .retired_cnt(retired_cnt), .done(done));

   pc_state_sequencer #(.CNT_W(3)) dut3 (
      .clk(clk), .rst(rst3), .stall(1'b0), .br_valid(1'b0), .br_target(8'd0),
      .pc(pc3), .state(state3), .retire(retire3), .retired_cnt(cnt3), .done(done3));

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one clock: drive inputs, check the retire pulse, advance the model, check state
   task automatic step(input logic r, input logic s, input logic bv, input logic [7:0] bt);
      int nxt;
      @(negedge clk);
      rst = r; stall = s; br_valid = bv; br_target = bt;
      #1;
      check("retire", int'(retire), int'(!m_done && m_ph == 5 && !s));
      @(posedge clk);
      if (r) begin
         m_ph = 0; m_pc = 0; m_rv = 0; m_cnt = 0; m_done = 0;
      end else if (!m_done && !s) begin
         if (m_ph == 3) begin
            m_rv = bv; m_rp = bt;
         end
         if (m_ph == 5) begin
            n_ret++;
            m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
            nxt = m_rv ? m_rp : m_pc + 1;
            m_rv = 0;
            if (m_pc == 11 || nxt > 11) m_done = 1;
            else begin
               m_pc = nxt; m_ph = 0;
            end
         end else m_ph++;
      end
      #1;
      check("pc", int'(pc), m_pc);
      check("state", int'(state), m_done ? 7 : m_ph);
      check("done", int'(done), m_done);
      check("retired_cnt", int'(retired_cnt), m_cnt);
   endtask

   initial begin
      repeat (2) step(1, 0, 0, 0);
      rst3 = 0;
      // straight-line program
      n_ret = 0;
      for (int i = 0; i < 80; i++) step(0, 0, 0, 0);
      check("t1_retires", n_ret, 12);
      check("t1_state", int'(state), 7);
      check("t1_pc", int'(pc), 11);
      check("t1_cnt", int'(retired_cnt), 12);
      // CNT_W=3 instance ran the same straight-line program
      check("sat_cnt", int'(cnt3), 7);
      check("sat_done", int'(done3), 1);
      check("sat_pc", int'(pc3), 11);
      // taken branch at pc=2, ignored branch in DECODE of pc=3
      step(1, 0, 0, 0);
      for (int i = 0; i < 30; i++)
         step(0, 0, (m_ph == 3 && m_pc == 2) || (m_ph == 1 && m_pc == 8), 8'd3);
      step(1, 0, 0, 0);
      for (int i = 0; i < 30; i++) step(0, 0, m_ph == 1 && m_pc == 3, 8'd9);
      check("t2_ignored", int'(pc) > 3 ? 1 : 0, 1);
      // stall + branch together in EXECUTE of pc=0, then a WB stall
      step(1, 0, 0, 0);
      stall_left = 3;
      for (int i = 0; i < 40; i++) begin
         logic s;
         s = (m_ph == 3 && m_pc == 0 && stall_left > 0) || (m_ph == 5 && m_pc == 5 && stall_left > -2);
         if (s) stall_left--;
         step(0, s, m_ph == 3 && m_pc == 0, 8'd5);
      end
      // out-of-range redirect at pc=4
      step(1, 0, 0, 0);
      for (int i = 0; i < 40; i++) step(0, 0, m_ph == 3 && m_pc == 4, 8'd200);
      check("t4_state", int'(state), 7);
      check("t4_pc", int'(pc), 4);
      check("t4_cnt", int'(retired_cnt), 5);
      // reset in MEM of pc=6 after a captured redirect
      step(1, 0, 0, 0);
      for (int i = 0; i < 60 && !(m_ph == 4 && m_pc == 6); i++) step(0, 0, m_ph == 3 && m_pc == 6, 8'd9);
      step(1, 0, 0, 0);
      check("t5_pc", int'(pc), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
      check("t5_no_redir", int'(pc), 1);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic r, s, bv;
         logic [7:0] bt;
         r = ($urandom_range(0, 99) == 0) || (m_done && $urandom_range(0, 7) == 0);
         s = $urandom_range(0, 3) == 0;
         bv = $urandom_range(0, 2) == 0;
         bt = $urandom_range(0, 9) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 11));
         step(r, s, bv, bt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
